// File: rtl/me_pkg.sv
// me_pkg: shared width helpers and FSM state for the SAD motion-estimation datapath
package me_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
  function automatic int row_sum_width(input int array_size);
    return 8 + $clog2(array_size);
  endfunction
  function automatic int sad_width(input int array_size);
    return 8 + 2 * $clog2(array_size);
  endfunction
endpackage

// File: rtl/ad_row_sum.sv
// ad_row_sum: adder tree over one row of 8-bit absolute differences, with the
// stage-1 register carrying the row sum and its valid/row_last/cand_last flags.
module ad_row_sum
  import me_pkg::*;
#(
  parameter int ARRAY_SIZE = 16,
  localparam int RW = row_sum_width(ARRAY_SIZE)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic                    in_row_last,
  input  logic                    in_cand_last,
  input  logic [ARRAY_SIZE*8-1:0] ad,
  output logic [RW-1:0]           row_sum,
  output logic                    row_valid,
  output logic                    row_last,
  output logic                    cand_last
);
  localparam int LG = $clog2(ARRAY_SIZE);
  logic [RW-1:0] row_sum_q, row_sum_d;
  logic          row_valid_q, row_valid_d;
  logic          row_last_q, row_last_d;
  logic          cand_last_q, cand_last_d;
  genvar l, k;
  for (l = 0; l <= LG; l++) begin : g_lvl
    logic [RW-1:0] s [ARRAY_SIZE >> l];
    for (k = 0; k < (ARRAY_SIZE >> l); k++) begin : g_n
      if (l == 0) begin : g_leaf
        assign s[k] = RW'(ad[8*k +: 8]);
      end else begin : g_add
        assign s[k] = g_lvl[l-1].s[2*k] + g_lvl[l-1].s[2*k+1];
      end
    end
  end
  always_comb begin
    row_sum_d   = clear ? '0 : g_lvl[LG].s[0];
    row_valid_d = !clear && in_valid;
    row_last_d  = !clear && in_valid && in_row_last;
    cand_last_d = !clear && in_valid && in_cand_last;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_sum_q   <= '0;
      row_valid_q <= 1'b0;
      row_last_q  <= 1'b0;
      cand_last_q <= 1'b0;
    end else begin
      row_sum_q   <= row_sum_d;
      row_valid_q <= row_valid_d;
      row_last_q  <= row_last_d;
      cand_last_q <= cand_last_d;
    end
  end
  assign row_sum   = row_sum_q;
  assign row_valid = row_valid_q;
  assign row_last  = row_last_q;
  assign cand_last = cand_last_q;
endmodule

// File: rtl/sad_min_search.sv
// sad_min_search: accumulates per-candidate SADs and tracks the minimum over a block search.
// Optional SAD_CAND_OUT_EN adds a per-candidate result stream (cand_valid/cand_sad/cand_idx_o).
module sad_min_search
  import me_pkg::*;
#(
  parameter int ARRAY_SIZE = 16,
  parameter int NUM_CAND   = 4,
  localparam int SAD_W = sad_width(ARRAY_SIZE),
  localparam int IW    = ($clog2(NUM_CAND) > 1) ? $clog2(NUM_CAND) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    ad_valid,
  input  logic [ARRAY_SIZE*8-1:0] ad,
  output logic                    busy,
  output logic                    done,
  output logic [SAD_W-1:0]        min_sad,
  output logic [IW-1:0]           min_idx
`ifdef SAD_CAND_OUT_EN
  ,
  output logic                    cand_valid,
  output logic [SAD_W-1:0]        cand_sad,
  output logic [IW-1:0]           cand_idx_o
`endif
);
  localparam int RW = row_sum_width(ARRAY_SIZE);
  localparam int CW = $clog2(ARRAY_SIZE);
  state_e           state_q, state_d;
  logic [CW-1:0]    row_cnt_q, row_cnt_d;
  logic [IW-1:0]    cand_cnt_q, cand_cnt_d;
  logic             fed_q, fed_d;
  logic [SAD_W-1:0] acc_q, acc_d;
  logic             mid_q, mid_d;
  logic             sad_valid_q, sad_valid_d;
  logic             sad_last_q, sad_last_d;
  logic [IW-1:0]    res_idx_q, res_idx_d;
  logic [SAD_W-1:0] min_sad_q, min_sad_d;
  logic [IW-1:0]    min_idx_q, min_idx_d;
  logic             done_q, done_d;
  logic             take, row_last, cand_last, upd;
  logic [RW-1:0]    rs_sum;
  logic             rs_valid, rs_row_last, rs_cand_last;
  ad_row_sum #(.ARRAY_SIZE(ARRAY_SIZE)) u_row_sum (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (start),
    .in_valid    (take),
    .in_row_last (row_last),
    .in_cand_last(cand_last),
    .ad          (ad),
    .row_sum     (rs_sum),
    .row_valid   (rs_valid),
    .row_last    (rs_row_last),
    .cand_last   (rs_cand_last)
  );
  // fed_q stops intake once the last row of the last candidate has entered the pipe
  always_comb begin
    take        = state_q == RUN && ad_valid && !start && !fed_q;
    row_last    = row_cnt_q == CW'(ARRAY_SIZE - 1);
    cand_last   = row_last && cand_cnt_q == IW'(NUM_CAND - 1);
    row_cnt_d   = start ? '0 : take ? row_cnt_q + 1'b1 : row_cnt_q;
    cand_cnt_d  = start ? '0 : (take && row_last && !cand_last) ? cand_cnt_q + 1'b1 : cand_cnt_q;
    fed_d       = !start && (fed_q || (take && cand_last));
    acc_d       = start ? '0 : !rs_valid ? acc_q : mid_q ? acc_q + SAD_W'(rs_sum) : SAD_W'(rs_sum);
    mid_d       = !start && (rs_valid ? !rs_row_last : mid_q);
    sad_valid_d = !start && rs_valid && rs_row_last;
    sad_last_d  = !start && rs_valid && rs_cand_last;
    upd         = sad_valid_q && (res_idx_q == '0 || acc_q < min_sad_q);
    min_sad_d   = start ? '1 : upd ? acc_q : min_sad_q;
    min_idx_d   = start ? '0 : upd ? res_idx_q : min_idx_q;
    res_idx_d   = start ? '0 : sad_valid_q ? res_idx_q + 1'b1 : res_idx_q;
    done_d      = !start && sad_valid_q && sad_last_q;
    state_d     = start ? RUN : (sad_valid_q && sad_last_q) ? IDLE : state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_cnt_q   <= '0;
      cand_cnt_q  <= '0;
      fed_q       <= 1'b0;
      acc_q       <= '0;
      mid_q       <= 1'b0;
      sad_valid_q <= 1'b0;
      sad_last_q  <= 1'b0;
      res_idx_q   <= '0;
      min_sad_q   <= '1;
      min_idx_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      cand_cnt_q  <= cand_cnt_d;
      fed_q       <= fed_d;
      acc_q       <= acc_d;
      mid_q       <= mid_d;
      sad_valid_q <= sad_valid_d;
      sad_last_q  <= sad_last_d;
      res_idx_q   <= res_idx_d;
      min_sad_q   <= min_sad_d;
      min_idx_q   <= min_idx_d;
      done_q      <= done_d;
    end
  end
  assign busy    = state_q == RUN;
  assign done    = done_q;
  assign min_sad = min_sad_q;
  assign min_idx = min_idx_q;
`ifdef SAD_CAND_OUT_EN
  logic             cand_valid_q, cand_valid_d;
  logic [SAD_W-1:0] cand_sad_q, cand_sad_d;
  logic [IW-1:0]    cand_idx_q, cand_idx_d;
  always_comb begin
    cand_valid_d = !start && sad_valid_q;
    cand_sad_d   = start ? '0 : sad_valid_q ? acc_q : cand_sad_q;
    cand_idx_d   = start ? '0 : sad_valid_q ? res_idx_q : cand_idx_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_valid_q <= 1'b0;
      cand_sad_q   <= '0;
      cand_idx_q   <= '0;
    end else begin
      cand_valid_q <= cand_valid_d;
      cand_sad_q   <= cand_sad_d;
      cand_idx_q   <= cand_idx_d;
    end
  end
  assign cand_valid = cand_valid_q;
  assign cand_sad   = cand_sad_q;
  assign cand_idx_o = cand_idx_q;
`endif
endmodule

// File: doc/sad_min_search.md
# sad_min_search

Downstream consumer of the PE line's packed absolute-difference bus. Each valid cycle it sums the ARRAY_SIZE 8-bit ADs of one row in a registered adder tree and accumulates ARRAY_SIZE rows into one candidate SAD. It compares each completed SAD against the running minimum and reports the best candidate index and SAD once all NUM_CAND candidates of a block search are done. It sits between the PE array and the motion-vector output logic.

## Interface
- ARRAY_SIZE, 16, ADs per row and rows per candidate; power of two, ≥2
- NUM_CAND, 4, candidates per search; ≥2
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a new search and clears all state
- ad_valid  in  1  ad carries a valid row this cycle
- ad  in  ARRAY_SIZE*8  packed ADs, element i at bits [8i+7:8i]
- busy  out  1  search in progress
- done  out  1  one-cycle pulse; results final
- min_sad  out  SAD_W  best SAD, where SAD_W = 8+2*log2(ARRAY_SIZE)
- min_idx  out  max(1,clog2(NUM_CAND))  candidate index of min_sad

## Operation
- Reset values: busy=0, done=0, min_sad=all ones, min_idx=0. All pipeline valids, counters and the accumulator are 0.
- FSM:
  - IDLE → RUN on start.
  - RUN → IDLE on the cycle done is asserted.
  - start in RUN restarts: counters, accumulator, pipeline valids and min regs are cleared to reset values.
  - The row sampled in the start cycle is discarded.
- ad_valid is ignored in IDLE. In RUN, rows are counted only when ad_valid=1. Gaps of any length are allowed.
- Stage 1: row_sum = sum of ARRAY_SIZE ADs, 8+log2(ARRAY_SIZE) bits, registered together with row_valid, row_last and cand_last flags.
- Stage 2: the accumulator loads row_sum on the first row of a candidate and adds it on later rows. SAD_W bits, no overflow possible (max 255·ARRAY_SIZE²).
- Stage 3, on the last row of a candidate:
  - If cand_idx==0 or sad < min_sad (strict): load min_sad and min_idx.
  - Ties therefore keep the lowest index.
- Row counter wraps ARRAY_SIZE-1→0 and increments the candidate counter.
- done fires on the stage-3 update of candidate NUM_CAND-1. busy drops in the same cycle.
- Rows arriving after the last row of the last candidate, while RUN is still active, are ignored.
- min_sad and min_idx hold until the next start or reset.

## Timing
- Final row sampled with ad_valid=1 in cycle N:
  - row_sum visible in N+1
  - accumulator complete in N+2
  - min_sad/min_idx updated and done=1 in N+3
- busy rises the cycle after start and is 0 from cycle N+3 onward.
- Throughput: one row per cycle sustained, no backpressure.
- Intermediate min_sad/min_idx change during RUN. They are only meaningful when done=1 and afterwards.
- rst_n assertion mid-search immediately forces reset values. No done is produced.

## Configuration
- SAD_CAND_OUT_EN defined:
  - Extra outputs cand_valid (1 bit), cand_sad (SAD_W bits) and cand_idx_o.
  - cand_valid pulses in stage 3 for every completed candidate, carrying its SAD and index. This is for debug and rate-distortion logic.
  - Reset value is 0 for all three.
- SAD_CAND_OUT_EN undefined: these ports and their registers do not exist. Core behaviour is identical in both builds.

## Structure
- Shared package me_pkg holds:
  - sad_width(array_size) and row_sum_width(array_size) functions
  - the FSM state enum (IDLE, RUN)
- Sub-module ad_row_sum contains the parameterised adder tree and stage-1 register. It is parameterised by ARRAY_SIZE and reusable by other SAD datapaths.
- The top level holds counters, accumulator, comparator and FSM.

## Test plan
Bench defaults: ARRAY_SIZE=16, NUM_CAND=4, 64 contiguous rows after start.
- Distinct candidates: all ADs 1/2/0/3 for candidates 0–3 → done with min_sad=0, min_idx=2, 3 cycles after the last row.
- Tie: all ADs =5 for every candidate → min_sad=1280, min_idx=0.
- Saturation width: all ADs =255 → min_sad=65280 (16'hFF00), no wrap.
- Bubbles: repeat the first case with ad_valid alternating 1/0 → identical result. done is in N+3 of the last valid row. busy stays high throughout the gaps.
- Restart: start after 20 rows, then repeat the tie stream → only the restarted data counts (1280, 0). Exactly one done.
- Reset mid-run: deassert rst_n at row 30 → outputs at reset values (min_sad=16'hFFFF, min_idx=0, busy=0) the same cycle. No done follows.
